// File: rtl/timer_bank_pkg.sv
// Shared types for the timer bank: channel modes, channel states and the
// per-channel command bundle.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_MOD     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic start;
    logic stop;
    logic load;
    logic ovf_clr;
  } chan_cmd_t;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: IDLE/RUN/DONE control, mode-dependent count step on the
// shared tick, registered terminal-count pulse and sticky overflow flag.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  chan_cmd_t        cmd_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [WIDTH-1:0] limit_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= ZERO;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Command priority: load, then stop, then start, then counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (cmd_i.load) begin
      count_d = load_data_i;
    end else if (cmd_i.stop) begin
      state_d = ST_IDLE;
    end else if (cmd_i.start && state_q != ST_RUN) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && tick_i) begin
      case (mode_i)
        MODE_UP: begin
          if (count_q == ALL1) begin
            count_d = ZERO;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
        MODE_DOWN: begin
          if (count_q == ZERO) begin
            count_d = ALL1;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - ONE;
          end
        end
        MODE_MOD: begin
          if (count_q >= limit_i) begin
            count_d = ZERO;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + ONE;
          end
        end
        MODE_ONESHOT: begin
          // Reaching 1 or already sitting at 0 both terminate the shot.
          if (count_q <= ONE) begin
            count_d = ZERO;
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            count_d = count_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Set while a terminal count is being registered or presented beats clear.
  always_comb begin
    ovf_d = ovf_q;
    if (tc_d || tc_q)
      ovf_d = 1'b1;
    else if (cmd_i.ovf_clr)
      ovf_d = 1'b0;
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = (state_q == ST_RUN);

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent timer channels sharing one free-running prescaler
// that produces the count tick.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NCH     = 4,
  parameter int PRESC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRESC_W-1:0]   prescale,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       load,
  input  logic [NCH-1:0]       ovf_clr,
  input  logic [NCH*WIDTH-1:0] load_data,
  input  logic [NCH*WIDTH-1:0] limit,
  input  logic [NCH*2-1:0]     mode,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       tc,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       busy
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  assign tick = (presc_q == prescale);

  // A value left above a freshly lowered prescale drops to 0 without ticking.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (presc_q >= prescale)
      presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    chan_cmd_t cmd;
    assign cmd.start   = start[g];
    assign cmd.stop    = stop[g];
    assign cmd.load    = load[g];
    assign cmd.ovf_clr = ovf_clr[g];

    timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .cmd_i       (cmd),
      .load_data_i (load_data[g*WIDTH +: WIDTH]),
      .limit_i     (limit[g*WIDTH +: WIDTH]),
      .mode_i      (mode_e'(mode[g*2 +: 2])),
      .count_o     (count[g*WIDTH +: WIDTH]),
      .tc_o        (tc[g]),
      .ovf_o       (ovf[g]),
      .busy_o      (busy[g])
    );
  end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: directed scenarios then random traffic,
// all checked against an arithmetic reference model.
module tb_timer_bank;

  localparam int W  = 4;
  localparam int N  = 3;
  localparam int PW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [PW-1:0]    prescale;
  logic [N-1:0]     start, stop, load, ovf_clr;
  logic [N*W-1:0]   load_data, limit;
  logic [N*2-1:0]   mode;
  logic [N*W-1:0]   count;
  logic [N-1:0]     tc, ovf, busy;

  timer_bank #(.WIDTH(W), .NCH(N), .PRESC_W(PW)) dut (
    .clk(clk), .rst(rst), .prescale(prescale),
    .start(start), .stop(stop), .load(load), .ovf_clr(ovf_clr),
    .load_data(load_data), .limit(limit), .mode(mode),
    .count(count), .tc(tc), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*W-1:0] cnt;
    logic [N-1:0]   tc;
    logic [N-1:0]   ovf;
    logic [N-1:0]   busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: 0 idle, 1 running, 2 done.
  int m_p;
  int m_cnt[N];
  int m_st[N];
  bit m_tc[N];
  bit m_ovf[N];

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic chk0(string name, int c, bit t, bit o, bit b);
    check({name, "_count"}, 64'(count[W-1:0]), 64'(c));
    check({name, "_tc"},    64'(tc[0]),        64'(t));
    check({name, "_ovf"},   64'(ovf[0]),       64'(o));
    check({name, "_busy"},  64'(busy[0]),      64'(b));
  endtask

  task automatic model_step();
    int   maxv;
    bit   tk;
    exp_t e;
    maxv = (1 << W) - 1;
    tk   = (m_p == int'(prescale));
    if (rst) begin
      m_p = 0;
      for (int c = 0; c < N; c++) begin
        m_cnt[c] = 0; m_st[c] = 0; m_tc[c] = 0; m_ovf[c] = 0;
      end
    end else begin
      m_p = (m_p >= int'(prescale)) ? 0 : m_p + 1;
      for (int c = 0; c < N; c++) begin
        int ld, lim, md;
        bit t;
        ld  = int'(load_data[c*W +: W]);
        lim = int'(limit[c*W +: W]);
        md  = int'(mode[c*2 +: 2]);
        t   = 0;
        if (load[c]) m_cnt[c] = ld;
        else if (stop[c]) m_st[c] = 0;
        else if (start[c] && m_st[c] != 1) m_st[c] = 1;
        else if (m_st[c] == 1 && tk) begin
          case (md)
            0: begin t = (m_cnt[c] == maxv); m_cnt[c] = (m_cnt[c] + 1) % (maxv + 1); end
            1: begin t = (m_cnt[c] == 0); m_cnt[c] = (m_cnt[c] + maxv) % (maxv + 1); end
            2: if (m_cnt[c] >= lim) begin t = 1; m_cnt[c] = 0; end
               else m_cnt[c] = m_cnt[c] + 1;
            default: if (m_cnt[c] <= 1) begin t = 1; m_cnt[c] = 0; m_st[c] = 2; end
                     else m_cnt[c] = m_cnt[c] - 1;
          endcase
        end
        m_ovf[c] = (t || m_tc[c]) ? 1'b1 : (ovf_clr[c] ? 1'b0 : m_ovf[c]);
        m_tc[c]  = t;
      end
    end
    for (int c = 0; c < N; c++) begin
      e.cnt[c*W +: W] = W'(m_cnt[c]);
      e.tc[c]   = m_tc[c];
      e.ovf[c]  = m_ovf[c];
      e.busy[c] = (m_st[c] == 1);
    end
    exp_q.push_back(e);
  endtask

  // Inputs are applied at the falling edge; the next rising edge consumes them.
  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_count", 64'(count), 64'(e.cnt));
        check("sb_tc",    64'(tc),    64'(e.tc));
        check("sb_ovf",   64'(ovf),   64'(e.ovf));
        check("sb_busy",  64'(busy),  64'(e.busy));
      end
    end
  end

  initial begin : stim
    m_p = 0;
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_st[c] = 0; m_tc[c] = 0; m_ovf[c] = 0;
    end
    rst = 1'b1; prescale = '0;
    start = '0; stop = '0; load = '0; ovf_clr = '0;
    load_data = '0; limit = '0; mode = '0;
    cyc(); cyc();
    check("rst_count", 64'(count), 64'd0);
    check("rst_flags", 64'({tc, ovf, busy}), 64'd0);
    rst = 1'b0;

    // Up-wrap at all-ones
    load[0] = 1'b1; load_data[W-1:0] = W'(14); cyc(); load[0] = 1'b0;
    start[0] = 1'b1; cyc(); start[0] = 1'b0;
    chk0("started", 14, 0, 0, 1);
    cyc(); chk0("wrap_15", 15, 0, 0, 1);
    cyc(); chk0("wrap_0", 0, 1, 1, 1);

    // Clear during the tc cycle loses, next cycle wins
    ovf_clr[0] = 1'b1; cyc(); chk0("ovf_hold", 1, 0, 1, 1);
    cyc(); chk0("ovf_clr", 2, 0, 0, 1);
    ovf_clr[0] = 1'b0;

    // load+stop+start together: load wins, state kept; then stop alone
    load[0] = 1'b1; stop[0] = 1'b1; start[0] = 1'b1; load_data[W-1:0] = W'(9);
    cyc(); chk0("ld_pri", 9, 0, 0, 1);
    load[0] = 1'b0; start[0] = 1'b0;
    cyc(); chk0("stop", 9, 0, 0, 0);
    stop[0] = 1'b0;

    // One-shot down from 3, then restart from DONE at 0
    mode[1:0] = 2'b11; load[0] = 1'b1; load_data[W-1:0] = W'(3); cyc(); load[0] = 1'b0;
    start[0] = 1'b1; cyc(); start[0] = 1'b0;
    cyc(); chk0("os_2", 2, 0, 0, 1);
    cyc(); chk0("os_1", 1, 0, 0, 1);
    cyc(); chk0("os_done", 0, 1, 1, 0);
    cyc(); chk0("os_hold", 0, 0, 1, 0);
    start[0] = 1'b1; cyc(); start[0] = 1'b0;
    chk0("os_restart", 0, 0, 1, 1);
    cyc(); chk0("os_tc0", 0, 1, 1, 0);

    // Modulo limit 2 with prescale 3 (sequence checked by the scoreboard)
    mode[1:0] = 2'b10; limit[W-1:0] = W'(2); prescale = PW'(3);
    load[0] = 1'b1; load_data[W-1:0] = '0; cyc(); load[0] = 1'b0;
    start[0] = 1'b1; cyc(); start[0] = 1'b0;
    repeat (24) cyc();

    // Reset while a down-wrap tc is due
    prescale = '0; mode[1:0] = 2'b01;
    start[1] = 1'b1; cyc(); start[1] = 1'b0;
    load[0] = 1'b1; load_data[W-1:0] = '0; cyc(); load[0] = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rstmid_count", 64'(count), 64'd0);
    check("rstmid_flags", 64'({tc, ovf, busy}), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0)
        prescale = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 2));
      for (int c = 0; c < N; c++) begin
        start[c]   = ($urandom_range(0, 7) == 0);
        stop[c]    = ($urandom_range(0, 24) == 0);
        load[c]    = ($urandom_range(0, 19) == 0);
        ovf_clr[c] = ($urandom_range(0, 5) == 0);
        load_data[c*W +: W] = W'($urandom);
        if ($urandom_range(0, 39) == 0) mode[c*2 +: 2] = 2'($urandom);
        if ($urandom_range(0, 39) == 0) limit[c*W +: W] = W'($urandom);
      end
      cyc();
    end
    rst = 1'b0; start = '0; stop = '0; load = '0; ovf_clr = '0;
    cyc();
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
